e203_exu_wbck_arb: RTL

E203_EXU_WBCK_ARB -- requirements
Module: e203_exu_wbck_arb

---
 rtl/e203_wbck_pkg.sv | 15 +
 rtl/e203_wbck_lpfifo.sv | 53 +++++
 rtl/e203_exu_wbck_arb.sv | 108 ++++++++++
 3 files changed

// File: rtl/e203_wbck_pkg.sv
// Shared widths and long-pipe buffer entry layout for the EXU writeback arbiter.
package e203_wbck_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned RFIDX_WIDTH = 5;

  typedef struct packed {
    logic [RFIDX_WIDTH-1:0] rdidx;
    logic [XLEN-1:0]        wdat;
    logic                   err;
  } lpbuf_entry_t;

  localparam int unsigned LPBUF_ENTRY_W = $bits(lpbuf_entry_t);

endpackage

// File: rtl/e203_wbck_lpfifo.sv
// Long-pipe writeback buffer: power-of-two FIFO (depth >= 2) whose pointers carry an extra wrap bit.
module e203_wbck_lpfifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_c = (wptr_q == rptr_q);
  assign full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_c  = mem_q[rptr_q[AW-1:0]];

  // A full buffer refuses pushes even when the head pops in the same cycle.
  assign do_push = push_i && !full_c;
  assign do_pop  = pop_i && !empty_c;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// EXU writeback arbiter: buffered long-pipe results win over ALU, with a starvation
// counter that forces an ALU grant; the winner is written to the regfile one cycle later.
module e203_exu_wbck_arb
  import e203_wbck_pkg::*;
#(
  parameter int unsigned LPBUF_DEPTH = 2,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wbck_i_valid,
  output logic                   alu_wbck_i_ready,
  input  logic [XLEN-1:0]        alu_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,
  input  logic                   longp_wbck_i_valid,
  output logic                   longp_wbck_i_ready,
  input  logic [XLEN-1:0]        longp_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0] longp_wbck_i_rdidx,
  input  logic                   longp_wbck_i_err,
  output logic                   wbck_dest_ena,
  output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
  output logic [XLEN-1:0]        wbck_dest_dat,
  output logic                   longp_pend
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  lpbuf_entry_t           push_entry, fifo_head;
  logic [LPBUF_ENTRY_W-1:0] fifo_head_raw;
  logic                   fifo_full, fifo_empty;
  logic                   alu_grant_c, fifo_grant_c, starve_force_c;
  logic [CNT_W-1:0]       starve_q, starve_d;
  logic                   dest_ena_q, dest_ena_d;
  logic [RFIDX_WIDTH-1:0] dest_idx_q, dest_idx_d;
  logic [XLEN-1:0]        dest_dat_q, dest_dat_d;
  logic [RFIDX_WIDTH-1:0] win_idx_c;
  logic [XLEN-1:0]        win_dat_c;
  logic                   win_err_c;

  assign push_entry = '{rdidx: longp_wbck_i_rdidx, wdat: longp_wbck_i_wdat, err: longp_wbck_i_err};
  assign fifo_head  = lpbuf_entry_t'(fifo_head_raw);

  e203_wbck_lpfifo #(
    .DEPTH (LPBUF_DEPTH),
    .WIDTH (LPBUF_ENTRY_W)
  ) u_lpfifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (longp_wbck_i_valid && !rst),
    .push_data_i (push_entry),
    .pop_i       (fifo_grant_c),
    .head_c      (fifo_head_raw),
    .full_c      (fifo_full),
    .empty_c     (fifo_empty)
  );

  // Buffered long-pipe head has priority unless the ALU has waited STARVE_MAX cycles.
  assign starve_force_c = (starve_q == CNT_W'(STARVE_MAX));
  assign alu_grant_c    = !rst && alu_wbck_i_valid && (fifo_empty || starve_force_c);
  assign fifo_grant_c   = !rst && !fifo_empty && !alu_grant_c;

  assign alu_wbck_i_ready   = alu_grant_c;
  assign longp_wbck_i_ready = !rst && !fifo_full;
  assign longp_pend         = !fifo_empty;

  always_comb begin
    starve_d = starve_q;
    if (!alu_wbck_i_valid || alu_grant_c) begin
      starve_d = '0;
    end else if (!starve_force_c) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Winner selection; a faulted or x0 destination is consumed without a regfile write.
  always_comb begin
    win_idx_c  = alu_grant_c ? alu_wbck_i_rdidx : fifo_head.rdidx;
    win_dat_c  = alu_grant_c ? alu_wbck_i_wdat  : fifo_head.wdat;
    win_err_c  = fifo_grant_c && fifo_head.err;
    dest_ena_d = 1'b0;
    dest_idx_d = dest_idx_q;
    dest_dat_d = dest_dat_q;
    if (alu_grant_c || fifo_grant_c) begin
      dest_ena_d = (win_idx_c != '0) && !win_err_c;
      dest_idx_d = win_idx_c;
      dest_dat_d = win_dat_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q   <= '0;
      dest_ena_q <= 1'b0;
      dest_idx_q <= '0;
      dest_dat_q <= '0;
    end else begin
      starve_q   <= starve_d;
      dest_ena_q <= dest_ena_d;
      dest_idx_q <= dest_idx_d;
      dest_dat_q <= dest_dat_d;
    end
  end

  assign wbck_dest_ena = dest_ena_q;
  assign wbck_dest_idx = dest_idx_q;
  assign wbck_dest_dat = dest_dat_q;

endmodule
